ps2_key_sequencer: RTL
======================

Name: ps2_key_sequencer

Overview:
Controller that owns the PS/2 keyboard byte stream from the keyboard receiver. It handshakes each scan byte, tracks E0 (extended) and F0 (break) prefixes, and keeps a held-key bitmap. It converts key state into game-tick-aligned move strobes with auto-repeat, and into a single restart pulse. It sits between the keyboard receiver and the game control FSM.

Parameters:
REPEAT_DELAY, 8, ticks from first move strobe to first auto-repeat strobe (1..255)
REPEAT_RATE, 2, ticks between auto-repeat strobes while held (1..255)

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
scan_code  in  8  byte from keyboard receiver, valid while scan_ready=1
scan_ready  in  1  level; receiver holds byte available
read  out  1  one-cycle acknowledge to receiver
tick  in  1  one-cycle game frame strobe
p1_up  out  1  one-cycle strobe, coincident with tick
p1_down  out  1  one-cycle strobe, coincident with tick
p2_up  out  1  one-cycle strobe, coincident with tick
p2_down  out  1  one-cycle strobe, coincident with tick
restart  out  1  one-cycle pulse on R make
held  out  5  {R, W, S, UP, DOWN}; 1 = key currently down

Behaviour:
- Reset (clock edge with reset=1): state=IDLE; ext=0, brk=0, held=0; repeat counters=0; pending=0; every output=0.
- Byte FSM:
  - IDLE: if scan_ready=1, latch scan_code, go to ACK.
  - ACK: read=1 for exactly this cycle; go to DECODE.
  - DECODE: process the latched byte; go to WAIT.
  - WAIT: stay until scan_ready=0, then go to IDLE. No second read for the same byte.
- Decode rules:
  - 8'hF0 sets brk=1. 8'hE0 sets ext=1. Prefixes are accepted in either order.
  - Any other byte uses the key map with the current ext, then clears ext and brk.
  - Key map, ext=0: 1D=W, 1B=S, 2D=R. Key map, ext=1: 75=UP, 72=DOWN.
  - Unmapped codes still clear the prefixes and have no other effect.
- Make (brk=0) on a key not already held: set its held bit.
  - If the key is W/S/UP/DOWN, set the owning player's pending flag.
  - If the key is R, pulse restart in the cycle after DECODE.
- Make on a key already held (keyboard typematic): ignored, no pending, no restart.
- Break (brk=1): clear the held bit. A break on a non-held key is a no-op.
- Move logic, per player (P1 = W/S, P2 = UP/DOWN), evaluated only on cycles with tick=1:
  - Direction: down if the down key is held, even when up is also held; else up if the up key is held; else none.
  - pending=1 and direction≠none: strobe direction this cycle, clear pending, counter=REPEAT_DELAY.
  - Else if direction≠none and counter=1: strobe, counter=REPEAT_RATE.
  - Else if counter>0: decrement.
  - direction=none: counter=0, pending=0, no strobe.
  - A key made and broken before the next tick produces no strobe (pending cleared when direction=none).
- Latency:
  - read asserts 1 cycle after scan_ready is first seen high in IDLE.
  - held updates 2 cycles after that (end of DECODE).
  - Move strobes appear only on tick cycles.
- Simultaneous events:
  - tick in the same cycle as a DECODE make: the tick evaluates the old held/pending; the new make strobes on the next tick.
  - The byte FSM and the tick logic are independent; neither stalls the other.
- Reset mid-operation: the latched byte and prefixes are discarded. If scan_ready is still high after reset, that byte is acknowledged as a fresh byte.
- Widths: counters are 8 bits. REPEAT_DELAY=1 gives a repeat on the next tick.

Optional Feature:
P2_KEYS_EN.
- Defined: UP/DOWN are decoded and p2_up/p2_down are driven as above.
- Undefined: E0-prefixed bytes still run the full handshake and prefix tracking but never change held. held[1:0]=0, p2_up=p2_down=0, and no P2 counters are instantiated.

Test Plan:
- Bytes 1D, then 5 ticks → read pulses once per byte; held=5'b01000; p1_up on first tick only; no repeat before tick 9 (REPEAT_DELAY=8).
- W held for 14 ticks → p1_up on ticks 1, 9, 11, 13.
- Bytes 1D, 1D, 1D (typematic) → single pending; one p1_up on next tick; restart stays 0.
- Bytes 1D, 1B, then tick → p1_down only (down priority). Then bytes F0, 1B and a tick → p1_up resumes via repeat counter.
- Bytes E0, 72, then E0, F0, 72 (and the F0, E0, 72 order) → held[0] sets then clears; p2_down once; unmapped byte 2A after E0 → no state change, ext cleared.
- Bytes 2D, 2D, F0, 2D, 2D → restart pulses exactly twice. reset asserted during WAIT with scan_ready high → outputs 0, byte re-acknowledged after reset.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-byte handshake, E0/F0 prefix decode, held-key bitmap and tick-aligned move strobes.
// Optional macro P2_KEYS_EN enables the UP/DOWN (player 2) keys and their repeat logic.
module ps2_key_sequencer #(
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       read,
    input  logic       tick,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       restart,
    output logic [4:0] held
);

    localparam logic [7:0] DelayInit = 8'(REPEAT_DELAY);
    localparam logic [7:0] RateInit  = 8'(REPEAT_RATE);

    typedef enum logic [1:0] {StIdle, StAck, StDecode, StWait} state_e;

    state_e     state;
    logic [7:0] byte_q;
    logic       ext_q;
    logic       brk_q;
    logic [4:0] key_sel;
    logic       r_make;
    logic       p1_make;
    logic       p1_pend;
    logic [7:0] p1_cnt;
    logic       p1_dir_up;
    logic       p1_dir_dn;
    logic       p1_fire;

    // held bit order: {R, W, S, UP, DOWN}
    always_comb begin
        key_sel = '0;
        if (!ext_q) begin
            case (byte_q)
                8'h1D:   key_sel[3] = 1'b1;
                8'h1B:   key_sel[2] = 1'b1;
                8'h2D:   key_sel[4] = 1'b1;
                default: key_sel = '0;
            endcase
        end
`ifdef P2_KEYS_EN
        else begin
            case (byte_q)
                8'h75:   key_sel[1] = 1'b1;
                8'h72:   key_sel[0] = 1'b1;
                default: key_sel = '0;
            endcase
        end
`endif
    end

    assign r_make  = !brk_q && key_sel[4] && !held[4];
    assign p1_make = !brk_q && |(key_sel[3:2] & ~held[3:2]);

    // Down wins when both keys of a player are held.
    assign p1_dir_dn = held[2];
    assign p1_dir_up = held[3] && !held[2];
    assign p1_fire   = tick && (p1_dir_up || p1_dir_dn) && (p1_pend || p1_cnt == 8'd1);
    assign p1_up     = p1_fire && p1_dir_up;
    assign p1_down   = p1_fire && p1_dir_dn;

`ifdef P2_KEYS_EN
    logic       p2_make;
    logic       p2_pend;
    logic [7:0] p2_cnt;
    logic       p2_dir_up;
    logic       p2_dir_dn;
    logic       p2_fire;

    assign p2_make   = !brk_q && |(key_sel[1:0] & ~held[1:0]);
    assign p2_dir_dn = held[0];
    assign p2_dir_up = held[1] && !held[0];
    assign p2_fire   = tick && (p2_dir_up || p2_dir_dn) && (p2_pend || p2_cnt == 8'd1);
    assign p2_up     = p2_fire && p2_dir_up;
    assign p2_down   = p2_fire && p2_dir_dn;
`else
    assign p2_up   = 1'b0;
    assign p2_down = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= StIdle;
            byte_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            held    <= '0;
            read    <= 1'b0;
            restart <= 1'b0;
            p1_pend <= 1'b0;
            p1_cnt  <= '0;
`ifdef P2_KEYS_EN
            p2_pend <= 1'b0;
            p2_cnt  <= '0;
`endif
        end else begin
            read    <= 1'b0;
            restart <= 1'b0;

            // Tick logic sees pre-decode held/pending; a same-cycle make overrides pending below.
            if (tick) begin
                if (!(p1_dir_up || p1_dir_dn)) begin
                    p1_cnt  <= '0;
                    p1_pend <= 1'b0;
                end else if (p1_pend) begin
                    p1_pend <= 1'b0;
                    p1_cnt  <= DelayInit;
                end else if (p1_cnt == 8'd1) begin
                    p1_cnt <= RateInit;
                end else if (p1_cnt != 8'd0) begin
                    p1_cnt <= p1_cnt - 8'd1;
                end
`ifdef P2_KEYS_EN
                if (!(p2_dir_up || p2_dir_dn)) begin
                    p2_cnt  <= '0;
                    p2_pend <= 1'b0;
                end else if (p2_pend) begin
                    p2_pend <= 1'b0;
                    p2_cnt  <= DelayInit;
                end else if (p2_cnt == 8'd1) begin
                    p2_cnt <= RateInit;
                end else if (p2_cnt != 8'd0) begin
                    p2_cnt <= p2_cnt - 8'd1;
                end
`endif
            end

            case (state)
                StIdle: begin
                    if (scan_ready) begin
                        byte_q <= scan_code;
                        read   <= 1'b1;
                        state  <= StAck;
                    end
                end
                StAck: state <= StDecode;
                StDecode: begin
                    if (byte_q == 8'hF0) begin
                        brk_q <= 1'b1;
                    end else if (byte_q == 8'hE0) begin
                        ext_q <= 1'b1;
                    end else begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        held  <= brk_q ? (held & ~key_sel) : (held | key_sel);
                        if (r_make)  restart <= 1'b1;
                        if (p1_make) p1_pend <= 1'b1;
`ifdef P2_KEYS_EN
                        if (p2_make) p2_pend <= 1'b1;
`endif
                    end
                    state <= StWait;
                end
                StWait: if (!scan_ready) state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
